// File: rtl/div_stall_unit_if.sv
// ----------------------------------------------------------------------------
// div_stall_unit_if
//   Groups the execute-stage divide request and its result/stall signals.
//   master : pipeline side (drives the request, receives result and stall)
//   slave  : divider side
// Signals
//   startE      DIV/DIVU occupies the E stage (held high while E is stalled)
//   signedE     1 = DIV (two's complement), 0 = DIVU
//   srcaE       dividend after forwarding
//   srcbE       divisor after forwarding
//   cancel      exception/flush, aborts any divide in progress
//   stall_reqE  stall request to the hazard unit
//   div_validE  one-cycle pulse, hi_o/lo_o valid, write HI/LO this cycle
//   hi_o        remainder
//   lo_o        quotient
// ----------------------------------------------------------------------------
interface div_stall_unit_if #(
  parameter int WIDTH = 32
);
  logic             startE;
  logic             signedE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             cancel;
  logic             stall_reqE;
  logic             div_validE;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output startE, signedE, srcaE, srcbE, cancel,
    input  stall_reqE, div_validE, hi_o, lo_o
  );

  modport slave (
    input  startE, signedE, srcaE, srcbE, cancel,
    output stall_reqE, div_validE, hi_o, lo_o
  );
endinterface

// File: rtl/div_stall_unit.sv
// ----------------------------------------------------------------------------
// div_stall_unit
//   Iterative radix-2 restoring divider for DIV/DIVU in the execute stage.
//   While a divide is in flight it requests a pipeline stall; when finished it
//   pulses div_validE for one cycle with HI (remainder) and LO (quotient).
//   Latency is WIDTH+2 cycles: start cycle, WIDTH BUSY steps, one DONE cycle.
// Ports
//   clk   clock, rising edge
//   rst   synchronous active-high reset
//   bus   div_stall_unit_if.slave (request in, stall/result out)
// ----------------------------------------------------------------------------
module div_stall_unit #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  div_stall_unit_if.slave     bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;      // partial remainder
  logic [WIDTH-1:0] quo_q;      // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] dvsr_q;     // divisor magnitude
  logic [WIDTH-1:0] a_raw_q;    // raw dividend, returned as HI on divide by zero
  logic             quo_neg_q;  // quotient sign for fix-up
  logic             rem_neg_q;  // remainder takes the dividend sign
  logic             div0_q;
  logic             valid_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  // Operand magnitudes for the start cycle.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  // One restoring step and the fix-up applied on the final step.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_d, quo_d;
  logic [WIDTH-1:0] hi_d, lo_d;

  // NOTE: every always_comb output gets a default on entry so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    a_neg    = bus.signedE & bus.srcaE[WIDTH-1];
    b_neg    = bus.signedE & bus.srcbE[WIDTH-1];
    a_mag    = a_neg ? (~bus.srcaE + 1'b1) : bus.srcaE;
    b_mag    = b_neg ? (~bus.srcbE + 1'b1) : bus.srcbE;

    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    rem_ge   = (rem_sh >= {1'b0, dvsr_q});
    rem_diff = rem_sh - {1'b0, dvsr_q};
    rem_d    = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_d    = {quo_q[WIDTH-2:0], rem_ge};

    // Negation wraps at WIDTH bits, so MIN / -1 yields MIN with no trap.
    lo_d     = quo_neg_q ? (~quo_d + 1'b1) : quo_d;
    hi_d     = rem_neg_q ? (~rem_d + 1'b1) : rem_d;
    if (div0_q) begin
      lo_d = '1;
      hi_d = a_raw_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (bus.cancel) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (bus.startE) begin
            state_q <= BUSY;
            cnt_q   <= '0;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= DONE;
            valid_q <= 1'b1;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the datapath registers carry no reset; they are always loaded in the
  // start cycle before the FSM consumes them, and hi_q/lo_q alone are visible.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.startE && !bus.cancel) begin
      rem_q     <= '0;
      quo_q     <= a_mag;
      dvsr_q    <= b_mag;
      a_raw_q   <= bus.srcaE;
      quo_neg_q <= a_neg ^ b_neg;
      rem_neg_q <= a_neg;
      div0_q    <= (bus.srcbE == '0);
    end else if (state_q == BUSY) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  // Stall is combinational so E already holds in the start cycle; cancel wins.
  assign bus.stall_reqE = !bus.cancel &&
                          ((state_q == IDLE && bus.startE) || state_q == BUSY);
  assign bus.div_validE = valid_q && !bus.cancel;
  assign bus.hi_o       = hi_q;
  assign bus.lo_o       = lo_q;

endmodule

// File: tb/tb_div_stall_unit.sv
// ----------------------------------------------------------------------------
// tb_div_stall_unit
//   Directed bench for div_stall_unit: reset, unsigned/signed divides,
//   overflow, divide by zero, cancel, back-to-back and reset mid-divide.
// ----------------------------------------------------------------------------
module tb_div_stall_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   cyc;

  div_stall_unit_if #(.WIDTH(32)) bus ();

  div_stall_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Runs one divide starting at the current negedge (DUT in IDLE). Returns at
  // the negedge of the DONE cycle, with done_cyc holding the cycle count then.
  task automatic do_div(input string name, input logic sgn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic hold, input logic [31:0] exp_lo,
                        input logic [31:0] exp_hi, output int done_cyc);
    int  stalls;
    bit  seen;
    stalls = 0;
    seen   = 1'b0;
    bus.signedE = sgn;
    bus.srcaE   = a;
    bus.srcbE   = b;
    bus.startE  = 1'b1;
    for (int n = 0; n < 60 && !seen; n++) begin
      #1;
      if (bus.div_validE) begin
        seen = 1'b1;
      end else begin
        if (bus.stall_reqE) stalls++;
        // Late operand changes after the start edge must be ignored.
        if (n == 1) begin
          bus.srcaE = ~a;
          bus.srcbE = 32'h3;
        end
        @(negedge clk);
      end
    end
    done_cyc = cyc;
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s timeout: div_validE never rose, stall cycles %0d", name, stalls);
    end
    n_checks++;
    if (stalls !== 33) begin
      n_fail++;
      $display("FAIL %s stall_cycles: got %0d expected 33", name, stalls);
    end
    n_checks++;
    if (bus.lo_o !== exp_lo) begin
      n_fail++;
      $display("FAIL %s lo_o: got %h expected %h", name, bus.lo_o, exp_lo);
    end
    n_checks++;
    if (bus.hi_o !== exp_hi) begin
      n_fail++;
      $display("FAIL %s hi_o: got %h expected %h", name, bus.hi_o, exp_hi);
    end
    n_checks++;
    if (bus.stall_reqE !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_stall: got %b expected 0", name, bus.stall_reqE);
    end
    if (!hold) bus.startE = 1'b0;
  endtask

  // One cycle later the pulse must be gone and the unit idle.
  task automatic check_after_done(input string name, input logic exp_stall);
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.div_validE !== 1'b0 || bus.stall_reqE !== exp_stall) begin
      n_fail++;
      $display("FAIL %s after_done: valid %b stall %b expected valid 0 stall %b",
               name, bus.div_validE, bus.stall_reqE, exp_stall);
    end
  endtask

  // Watches for a spurious valid pulse over a number of cycles.
  task automatic check_no_pulse(input string name, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      #1;
      if (bus.div_validE) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL %s no_pulse: got %0d pulses expected 0", name, pulses);
    end
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.startE  = 1'b0;
    bus.signedE = 1'b0;
    bus.srcaE   = '0;
    bus.srcbE   = '0;
    bus.cancel  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (bus.stall_reqE !== 1'b0 || bus.div_validE !== 1'b0) begin
      n_fail++;
      $display("FAIL reset ctrl: stall %b valid %b expected 0 0",
               bus.stall_reqE, bus.div_validE);
    end
    n_checks++;
    if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset data: hi %h lo %h expected 0 0", bus.hi_o, bus.lo_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_divu();
    int t;
    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, t);
    check_after_done("divu_100_7", 1'b0);
  endtask

  task automatic test_div_signed();
    int t;
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0,
           32'hFFFF_FFFD, 32'hFFFF_FFFF, t);
    check_after_done("div_m7_2", 1'b0);
    do_div("div_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 1'b0,
           32'hFFFF_FFF2, 32'd2, t);
    check_after_done("div_100_m7", 1'b0);
  endtask

  task automatic test_overflow();
    int t;
    do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0,
           32'h8000_0000, 32'h0, t);
    check_after_done("div_ovf", 1'b0);
  endtask

  task automatic test_div_zero();
    int t;
    do_div("div0_signed", 1'b1, 32'hFFFF_FFF8, 32'h0, 1'b0,
           32'hFFFF_FFFF, 32'hFFFF_FFF8, t);
    check_after_done("div0_signed", 1'b0);
    do_div("divu_5_0", 1'b0, 32'd5, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'd5, t);
    check_after_done("divu_5_0", 1'b0);
  endtask

  // Starts 100/7, cancels in BUSY cycle 10; previous result is divu 5/0.
  task automatic test_cancel();
    bus.signedE = 1'b0;
    bus.srcaE   = 32'd100;
    bus.srcbE   = 32'd7;
    bus.startE  = 1'b1;
    repeat (10) @(negedge clk);
    bus.cancel = 1'b1;
    #1;
    n_checks++;
    if (bus.stall_reqE !== 1'b0 || bus.div_validE !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel cycle: stall %b valid %b expected 0 0",
               bus.stall_reqE, bus.div_validE);
    end
    @(negedge clk);
    bus.cancel = 1'b0;
    bus.startE = 1'b0;
    #1;
    n_checks++;
    if (bus.stall_reqE !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel idle_stall: got %b expected 0", bus.stall_reqE);
    end
    n_checks++;
    if (bus.lo_o !== 32'hFFFF_FFFF || bus.hi_o !== 32'd5) begin
      n_fail++;
      $display("FAIL cancel held_result: lo %h hi %h expected ffffffff 00000005",
               bus.lo_o, bus.hi_o);
    end
    check_no_pulse("cancel", 40);
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    do_div("b2b_9_3", 1'b0, 32'd9, 32'd3, 1'b1, 32'd3, 32'd0, t1);
    bus.srcaE = 32'd10;
    bus.srcbE = 32'd4;
    check_after_done("b2b_9_3", 1'b1);
    do_div("b2b_10_4", 1'b0, 32'd10, 32'd4, 1'b0, 32'd2, 32'd2, t2);
    n_checks++;
    if (t2 - t1 != 34) begin
      n_fail++;
      $display("FAIL b2b spacing: got %0d cycles expected 34", t2 - t1);
    end
    check_after_done("b2b_10_4", 1'b0);
  endtask

  task automatic test_reset_mid();
    bus.signedE = 1'b0;
    bus.srcaE   = 32'd100;
    bus.srcbE   = 32'd7;
    bus.startE  = 1'b1;
    repeat (6) @(negedge clk);
    bus.startE = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.stall_reqE !== 1'b0 || bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid state: stall %b hi %h lo %h expected 0 0 0",
               bus.stall_reqE, bus.hi_o, bus.lo_o);
    end
    check_no_pulse("reset_mid", 40);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_divu();
    test_div_signed();
    test_overflow();
    test_div_zero();
    test_cancel();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
